dark_channel_window: RTL and testbench

Downstream consumer of the three-row line-buffer stage in the haze-removal pipeline. Takes three vertically aligned 24-bit RGB pixels per column (row above, current row, row below), computes the per-pixel minimum channel, then computes the 3x3 spatial minimum, giving the dark-channel value. Output is an 8-bit dark-channel stream, one value per image column, for the atmospheric-light and transmission stages.

---
 rtl/dark_channel_window_pkg.sv | 37 +++
 rtl/dark_channel_window_if.sv | 24 ++
 rtl/dark_channel_window_rgb_min.sv | 24 ++
 rtl/dark_channel_window.sv | 120 ++++++++++++
 tb/tb_dark_channel_window.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dark_channel_window_pkg.sv
// Shared constants, types and helpers for the dark-channel window stage.
//   CHANNEL_WIDTH / PIXEL_WIDTH     : colour channel and packed RGB widths
//   DEFAULT_IMAGE_WIDTH             : default pixels per row (matches line buffer)
//   R_LSB / G_LSB / B_LSB           : channel slice offsets inside a packed pixel
//   min3                            : unsigned minimum of three channel values
package dark_channel_window_pkg;

    localparam int unsigned CHANNEL_WIDTH       = 8;
    localparam int unsigned PIXEL_WIDTH         = 24;
    localparam int unsigned DEFAULT_IMAGE_WIDTH = 512;

    localparam int unsigned R_LSB = 16;
    localparam int unsigned G_LSB = 8;
    localparam int unsigned B_LSB = 0;

    typedef logic [CHANNEL_WIDTH-1:0] chan_t;
    typedef logic [PIXEL_WIDTH-1:0]   pixel_t;

    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_FLUSH  = 1'b1
    } state_e;

    // Sideband that travels with each column through the pipeline.
    typedef struct packed {
        logic valid;   // a real column was accepted
        logic first;   // that column is column 0 of a row
        logic flush;   // right-border replicate shift, no new column
    } tag_t;

    function automatic chan_t min3(input chan_t a, input chan_t b, input chan_t c);
        chan_t m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/dark_channel_window_if.sv
// Column-in / dark-pixel-out bus of the dark-channel window stage.
//   master : upstream line buffer + downstream consumer (drives rows, valid)
//   slave  : dark_channel_window (drives ready, dark_pixel, output_is_valid)
interface dark_channel_window_if;
    import dark_channel_window_pkg::*;

    pixel_t row0_pixel;
    pixel_t row1_pixel;
    pixel_t row2_pixel;
    logic   input_is_valid;
    logic   input_ready;
    chan_t  dark_pixel;
    logic   output_is_valid;

    modport master (
        output row0_pixel, row1_pixel, row2_pixel, input_is_valid,
        input  input_ready, dark_pixel, output_is_valid
    );

    modport slave (
        input  row0_pixel, row1_pixel, row2_pixel, input_is_valid,
        output input_ready, dark_pixel, output_is_valid
    );
endinterface

// File: rtl/dark_channel_window_rgb_min.sv
// Registered minimum over the R, G and B channels of one packed pixel.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   pixel    : packed RGB input
//   ch_min   : min(R,G,B), one cycle later
module rgb_min
    import dark_channel_window_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  pixel_t pixel,
    output chan_t  ch_min
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_min <= '0;
        end else begin
            ch_min <= min3(pixel[R_LSB +: CHANNEL_WIDTH],
                           pixel[G_LSB +: CHANNEL_WIDTH],
                           pixel[B_LSB +: CHANNEL_WIDTH]);
        end
    end

endmodule

// File: rtl/dark_channel_window.sv
// 3x3 dark-channel filter: per-pixel channel min, vertical min over three
// rows, then horizontal min over a three-column window with replicated
// left/right borders. One dark_pixel per accepted column, 4-cycle latency.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : column input handshake and dark-pixel output strobe
module dark_channel_window
    import dark_channel_window_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH = DEFAULT_IMAGE_WIDTH
) (
    input logic                  clk,
    input logic                  rst,
    dark_channel_window_if.slave bus
);

    localparam int unsigned COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_WIDTH - 1);

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q;
    logic             ready;
    logic             accept;

    chan_t ch_min0, ch_min1, ch_min2;
    tag_t  s1_tag, s2_tag;
    chan_t col_min_q;
    chan_t win_l, win_c, win_r;
    logic  emit_q;
    chan_t dark_q;
    logic  out_valid_q;

    assign ready  = (state_q == ST_ACCEPT);
    assign accept = bus.input_is_valid & ready;

    assign bus.input_ready     = ready;
    assign bus.dark_pixel      = dark_q;
    assign bus.output_is_valid = out_valid_q;

    // Row-end control: one non-accepting cycle after the last column.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCEPT: if (accept && (col_q == LAST_COL)) state_d = ST_FLUSH;
            ST_FLUSH:  state_d = ST_ACCEPT;
            default:   state_d = ST_ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCEPT;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                col_q <= (col_q == LAST_COL) ? '0 : col_q + COL_W'(1);
            end
        end
    end

    // Stage 1: channel minimum per row.
    rgb_min u_min_row0 (.clk(clk), .rst(rst), .pixel(bus.row0_pixel), .ch_min(ch_min0));
    rgb_min u_min_row1 (.clk(clk), .rst(rst), .pixel(bus.row1_pixel), .ch_min(ch_min1));
    rgb_min u_min_row2 (.clk(clk), .rst(rst), .pixel(bus.row2_pixel), .ch_min(ch_min2));

    // Stage 1 tag and stage 2 vertical minimum.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_tag    <= '0;
            s2_tag    <= '0;
            col_min_q <= '0;
        end else begin
            s1_tag    <= '{valid: accept,
                           first: accept && (col_q == '0),
                           flush: (state_q == ST_FLUSH)};
            s2_tag    <= s1_tag;
            col_min_q <= min3(ch_min0, ch_min1, ch_min2);
        end
    end

    // Horizontal window. Column 0 fills C and Rw (left replicate, no output);
    // the flush shift re-uses Rw as its own right neighbour.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_l  <= '0;
            win_c  <= '0;
            win_r  <= '0;
            emit_q <= 1'b0;
        end else begin
            emit_q <= 1'b0;
            if (s2_tag.valid && s2_tag.first) begin
                win_c <= col_min_q;
                win_r <= col_min_q;
            end else if (s2_tag.valid) begin
                win_l  <= win_c;
                win_c  <= win_r;
                win_r  <= col_min_q;
                emit_q <= 1'b1;
            end else if (s2_tag.flush) begin
                win_l  <= win_c;
                win_c  <= win_r;
                emit_q <= 1'b1;
            end
        end
    end

    // Stage 3: horizontal minimum and output strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            dark_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= emit_q;
            if (emit_q) begin
                dark_q <= min3(win_l, win_c, win_r);
            end
        end
    end

endmodule

// File: tb/tb_dark_channel_window.sv
// Self-checking bench for dark_channel_window with an 8-pixel image width.
module tb_dark_channel_window;

    localparam int W = 8;

    typedef logic [0:W-1][23:0] row_t;
    typedef struct {
        string              name;
        row_t               r0, r1, r2;
        logic [0:W-1][7:0]  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int errs   = 0;
    int checks = 0;

    int out_q[$];
    int out_cyc[$];
    int acc_q[$];
    int exp_q[$];

    vec_t vecs[3];

    dark_channel_window_if bus ();

    dark_channel_window #(.IMAGE_WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.output_is_valid) begin
            out_q.push_back(int'(bus.dark_pixel));
            out_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: min over every channel of the 3x3 neighbourhood, columns clamped.
    function automatic int chan_min(input logic [23:0] p);
        int m = 255;
        for (int k = 0; k < 3; k++) begin
            int v = int'(p[8*k +: 8]);
            if (v < m) m = v;
        end
        return m;
    endfunction

    function automatic int ref_dark(input row_t r0, input row_t r1, input row_t r2, input int c);
        int m = 255;
        for (int dc = -1; dc <= 1; dc++) begin
            int cc = c + dc;
            if (cc < 0) cc = 0;
            if (cc > W - 1) cc = W - 1;
            if (chan_min(r0[cc]) < m) m = chan_min(r0[cc]);
            if (chan_min(r1[cc]) < m) m = chan_min(r1[cc]);
            if (chan_min(r2[cc]) < m) m = chan_min(r2[cc]);
        end
        return m;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int c = 0; c < W; c++) r[c] = 24'($urandom);
        return r;
    endfunction

    task automatic clear_queues();
        out_q.delete();
        out_cyc.delete();
        acc_q.delete();
        exp_q.delete();
    endtask

    // Presents ncols columns; valid stays high after the last one is accepted.
    task automatic send_row(input row_t r0, input row_t r1, input row_t r2,
                            input int gap_pct, input int ncols);
        for (int c = 0; c < ncols; c++) begin
            bit acc;
            int a_cyc;
            int waited;
            if (int'($urandom_range(99)) < gap_pct) begin
                repeat (int'($urandom_range(1, 3))) begin
                    bus.input_is_valid = 1'b0;
                    bus.row0_pixel = 24'($urandom);
                    bus.row1_pixel = 24'($urandom);
                    bus.row2_pixel = 24'($urandom);
                    @(posedge clk); #1;
                end
            end
            bus.row0_pixel     = r0[c];
            bus.row1_pixel     = r1[c];
            bus.row2_pixel     = r2[c];
            bus.input_is_valid = 1'b1;
            acc    = 1'b0;
            a_cyc  = 0;
            waited = 0;
            while (!acc) begin
                acc   = bus.input_ready;
                a_cyc = cyc;
                @(posedge clk); #1;
                if (!acc) begin
                    waited++;
                    if (waited > 4) begin
                        chk("ready_timeout", 0, 1);
                        break;
                    end
                end
            end
            if (acc) acc_q.push_back(a_cyc);
        end
    endtask

    task automatic wait_outputs(input int n);
        for (int i = 0; i < 100 && out_q.size() < n; i++) begin
            @(posedge clk); #1;
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    // Values in order, plus cycle of each output relative to its trigger.
    task automatic check_stream(input string name);
        int n = exp_q.size();
        chk({name, "_count"}, out_q.size(), n);
        for (int k = 0; k < n && k < out_q.size(); k++) begin
            int want_cyc;
            chk({name, "_val"}, out_q[k], exp_q[k]);
            if ((k % W) != W - 1) begin
                want_cyc = (k + 1 < acc_q.size()) ? acc_q[k + 1] + 4 : -1;
            end else begin
                want_cyc = (k < acc_q.size()) ? acc_q[k] + 5 : -1;
            end
            chk({name, "_cycle"}, out_cyc[k], want_cyc);
        end
    endtask

    initial begin
        bus.row0_pixel     = '0;
        bus.row1_pixel     = '0;
        bus.row2_pixel     = '0;
        bus.input_is_valid = 1'b0;

        // Directed vectors.
        for (int v = 0; v < 3; v++) begin
            for (int c = 0; c < W; c++) begin
                vecs[v].r0[c] = 24'hFFFFFF;
                vecs[v].r1[c] = 24'hFFFFFF;
                vecs[v].r2[c] = 24'hFFFFFF;
            end
        end
        vecs[0].name = "flat";
        for (int c = 0; c < W; c++) begin
            vecs[0].r0[c] = 24'h808080;
            vecs[0].r1[c] = 24'h808080;
            vecs[0].r2[c] = 24'h808080;
            vecs[0].exp[c] = 8'h80;
        end
        vecs[1].name = "dark_dot";
        vecs[1].r1[3] = 24'h10FFFF;
        for (int c = 0; c < W; c++) vecs[1].exp[c] = (c >= 2 && c <= 4) ? 8'h10 : 8'hFF;
        vecs[2].name = "borders";
        vecs[2].r0[0] = 24'h050505;
        vecs[2].r2[7] = 24'h070707;
        for (int c = 0; c < W; c++) begin
            vecs[2].exp[c] = (c <= 1) ? 8'h05 : ((c >= 6) ? 8'h07 : 8'hFF);
        end

        // Reset state.
        @(posedge clk); #1;
        chk("rst_ready", int'(bus.input_ready), 1);
        chk("rst_ovalid", int'(bus.output_is_valid), 0);
        chk("rst_dark", int'(bus.dark_pixel), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_ovalid", int'(bus.output_is_valid), 0);
        clear_queues();

        // Table-driven gapless rows with row-end ready check.
        for (int v = 0; v < 3; v++) begin
            clear_queues();
            send_row(vecs[v].r0, vecs[v].r1, vecs[v].r2, 0, W);
            chk({vecs[v].name, "_ready_low"}, int'(bus.input_ready), 0);
            bus.input_is_valid = 1'b0;
            @(posedge clk); #1;
            chk({vecs[v].name, "_ready_back"}, int'(bus.input_ready), 1);
            wait_outputs(W);
            for (int c = 0; c < W; c++) exp_q.push_back(int'(vecs[v].exp[c]));
            check_stream(vecs[v].name);
        end

        // Random back-to-back rows with gaps; valid is held through each flush.
        begin
            row_t ra[4], rb[4], rc[4];
            clear_queues();
            for (int r = 0; r < 4; r++) begin
                ra[r] = rand_row();
                rb[r] = rand_row();
                rc[r] = rand_row();
                for (int c = 0; c < W; c++) exp_q.push_back(ref_dark(ra[r], rb[r], rc[r], c));
            end
            for (int r = 0; r < 4; r++) send_row(ra[r], rb[r], rc[r], 30, W);
            bus.input_is_valid = 1'b0;
            wait_outputs(4 * W);
            check_stream("bubbly");
        end

        // Reset in the middle of a row.
        begin
            row_t ra, rb, rc;
            clear_queues();
            send_row(rand_row(), rand_row(), rand_row(), 0, 5);
            bus.input_is_valid = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1;
            out_q.delete();
            out_cyc.delete();
            @(posedge clk); #1;
            rst = 1'b0;
            repeat (6) @(posedge clk);
            #1;
            chk("mid_rst_quiet", out_q.size(), 0);
            chk("mid_rst_ready", int'(bus.input_ready), 1);
            clear_queues();
            ra = rand_row();
            rb = rand_row();
            rc = rand_row();
            for (int c = 0; c < W; c++) exp_q.push_back(ref_dark(ra, rb, rc, c));
            send_row(ra, rb, rc, 0, W);
            bus.input_is_valid = 1'b0;
            wait_outputs(W);
            check_stream("after_rst");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
